// File: rtl/sc_meas_pkg.sv
// rtl/sc_meas_pkg.sv - shared types and defaults for the stochastic correlation meter
package sc_meas_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SKIP  = 2'd1,
      COUNT = 2'd2,
      DONE  = 2'd3
   } corr_meter_state_t;

   localparam int DEFAULT_N_BITS  = 8;
   localparam int DEFAULT_LATENCY = 1;

   // One extra bit so a full window of ones (2^n_bits) fits without wrapping.
   function automatic int cnt_width(input int n_bits);
      return n_bits + 1;
   endfunction

endpackage

// File: rtl/sc_ones_counter.sv
// rtl/sc_ones_counter.sv - ones counter with synchronous clear and enable
module sc_ones_counter
   import sc_meas_pkg::*;
#(
   parameter int W = cnt_width(DEFAULT_N_BITS)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   input  logic         bit_in,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && bit_in) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/sc_corr_meter.sv
// rtl/sc_corr_meter.sv - windowed SCC=+1/-1 meter for a pair of stochastic bitstreams
module sc_corr_meter
   import sc_meas_pkg::*;
#(
   parameter int N_BITS  = DEFAULT_N_BITS,
   parameter int LATENCY = DEFAULT_LATENCY
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              x,
   input  logic              y,
   output logic              busy,
   output logic              done,
   output logic              valid,
   output logic [N_BITS:0]   cnt_x,
   output logic [N_BITS:0]   cnt_y,
   output logic [N_BITS:0]   cnt_xy,
   output logic              pos_corr,
   output logic              neg_corr
);

   localparam int              CW        = cnt_width(N_BITS);
   localparam logic [N_BITS:0] WINDOW    = {1'b1, {N_BITS{1'b0}}};
   localparam logic [3:0]      SKIP_LAST = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

   corr_meter_state_t state, state_nxt;
   logic [N_BITS:0]   sample_cnt;
   logic [3:0]        skip_cnt;
   logic              accept;
   logic              last_skip;
   logic              last_sample;
   logic              counting;

   assign accept      = (state == IDLE) && start;
   assign last_skip   = (skip_cnt == SKIP_LAST);
   assign last_sample = ((sample_cnt + 1'b1) == WINDOW);
   assign counting    = (state == COUNT);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (LATENCY > 0) ? SKIP : COUNT;
         SKIP:    if (last_skip) state_nxt = COUNT;
         COUNT:   if (last_sample) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         skip_cnt   <= '0;
         sample_cnt <= '0;
         valid      <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            skip_cnt   <= '0;
            sample_cnt <= '0;
            valid      <= 1'b0;
         end else begin
            if (state == SKIP) skip_cnt <= skip_cnt + 1'b1;
            if (counting) sample_cnt <= sample_cnt + 1'b1;
            // Raised with the last sample so it is already high in the done cycle.
            if (counting && last_sample) valid <= 1'b1;
         end
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   sc_ones_counter #(.W(CW)) u_cnt_x (
      .clk(clk), .rst_n(rst_n), .clr(accept), .en(counting), .bit_in(x), .cnt(cnt_x)
   );

   sc_ones_counter #(.W(CW)) u_cnt_y (
      .clk(clk), .rst_n(rst_n), .clr(accept), .en(counting), .bit_in(y), .cnt(cnt_y)
   );

   sc_ones_counter #(.W(CW)) u_cnt_xy (
      .clk(clk), .rst_n(rst_n), .clr(accept), .en(counting), .bit_in(x & y), .cnt(cnt_xy)
   );

   // Maximal negative correlation floor: max(0, cnt_x + cnt_y - window).
   logic [N_BITS:0]   cnt_min;
   logic [N_BITS+1:0] sum_xy;
   logic [N_BITS+1:0] neg_floor;

   assign cnt_min   = (cnt_x < cnt_y) ? cnt_x : cnt_y;
   assign sum_xy    = {1'b0, cnt_x} + {1'b0, cnt_y};
   assign neg_floor = (sum_xy > {1'b0, WINDOW}) ? (sum_xy - {1'b0, WINDOW}) : '0;

   assign pos_corr = valid && (cnt_xy == cnt_min);
   assign neg_corr = valid && ({1'b0, cnt_xy} == neg_floor);

endmodule

// File: tb/tb_sc_corr_meter.sv
// tb/tb_sc_corr_meter.sv - scoreboard bench for sc_corr_meter at N_BITS=4
module tb_sc_corr_meter;
   import sc_meas_pkg::*;

   localparam int NB  = 4;
   localparam int WIN = 16;

   logic clk = 1'b0;
   logic rst_n, x, y, start0, start1;
   logic busy0, done0, valid0, pos0, neg0;
   logic busy1, done1, valid1, pos1, neg1;
   logic [NB:0] cx0, cy0, cxy0, cx1, cy1, cxy1;

   always #5 clk = ~clk;

   sc_corr_meter #(.N_BITS(NB), .LATENCY(0)) u_lat0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .x(x), .y(y),
      .busy(busy0), .done(done0), .valid(valid0),
      .cnt_x(cx0), .cnt_y(cy0), .cnt_xy(cxy0),
      .pos_corr(pos0), .neg_corr(neg0)
   );

   sc_corr_meter #(.N_BITS(NB), .LATENCY(2)) u_lat2 (
      .clk(clk), .rst_n(rst_n), .start(start1), .x(x), .y(y),
      .busy(busy1), .done(done1), .valid(valid1),
      .cnt_x(cx1), .cnt_y(cy1), .cnt_xy(cxy1),
      .pos_corr(pos1), .neg_corr(neg1)
   );

   logic        sel;
   logic        m_busy, m_done, m_valid, m_pos, m_neg;
   logic [NB:0] m_cx, m_cy, m_cxy;

   always_comb begin
      m_busy  = sel ? busy1  : busy0;
      m_done  = sel ? done1  : done0;
      m_valid = sel ? valid1 : valid0;
      m_pos   = sel ? pos1   : pos0;
      m_neg   = sel ? neg1   : neg0;
      m_cx    = sel ? cx1    : cx0;
      m_cy    = sel ? cy1    : cy0;
      m_cxy   = sel ? cxy1   : cxy0;
   end

   typedef struct {
      logic [NB:0] cx;
      logic [NB:0] cy;
      logic [NB:0] cxy;
      logic        pos;
      logic        neg;
      int          done_edge;
   } exp_t;

   exp_t sb[$];
   exp_t last_e;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic set_start(input logic v);
      if (sel) start1 = v;
      else     start0 = v;
   endtask

   // Reference model: samples are pattern bits lat .. lat+WIN-1.
   task automatic push_expected(input int lat, input logic [31:0] px, input logic [31:0] py);
      exp_t e;
      int   a, b, c, lo, mn;
      a = 0; b = 0; c = 0;
      for (int i = lat; i < lat + WIN; i++) begin
         a += int'(px[i]);
         b += int'(py[i]);
         c += int'(px[i] & py[i]);
      end
      lo = (a + b > WIN) ? a + b - WIN : 0;
      mn = (a < b) ? a : b;
      e.cx  = a[NB:0];
      e.cy  = b[NB:0];
      e.cxy = c[NB:0];
      e.pos = (c == mn);
      e.neg = (c == lo);
      e.done_edge = lat + WIN;
      sb.push_back(e);
   endtask

   task automatic run_window(input logic s, input int lat, input logic [31:0] px,
                             input logic [31:0] py, input logic restart);
      int   done_seen;
      int   total;
      exp_t e;
      done_seen = 0;
      total     = lat + WIN + 1;
      sel       = s;
      @(negedge clk);
      set_start(1'b1);
      x = 1'b0;
      y = 1'b0;
      push_expected(lat, px, py);
      @(posedge clk);
      #1;
      check("busy_rise", m_busy, 1);
      check("valid_clr", m_valid, 0);
      check("cnt_clr", m_cx, 0);
      for (int k = 1; k <= total; k++) begin
         @(negedge clk);
         x = (k - 1 < lat + WIN) ? px[k-1] : 1'b0;
         y = (k - 1 < lat + WIN) ? py[k-1] : 1'b0;
         set_start(restart);
         @(posedge clk);
         #1;
         if (m_done) begin
            done_seen++;
            if (sb.size() == 0) begin
               check("sb_underflow", 1, 0);
            end else begin
               e = sb.pop_front();
               last_e = e;
               check("done_edge", k, e.done_edge);
               check("cnt_x", m_cx, e.cx);
               check("cnt_y", m_cy, e.cy);
               check("cnt_xy", m_cxy, e.cxy);
               check("pos_corr", m_pos, e.pos);
               check("neg_corr", m_neg, e.neg);
               check("valid_at_done", m_valid, 1);
            end
         end
      end
      check("done_pulses", done_seen, 1);
      check("busy_fall", m_busy, 0);
      @(negedge clk);
      set_start(1'b0);
      x = 1'b1;
      y = 1'b1;
      @(posedge clk);
      #1;
      check("hold_valid", m_valid, 1);
      check("hold_cnt_x", m_cx, last_e.cx);
      check("hold_cnt_xy", m_cxy, last_e.cxy);
   endtask

   initial begin
      logic [31:0] alt, alt2, rx, ry;
      int          dn;
      alt  = '0;
      alt2 = '0;
      for (int i = 0; i < 32; i++) begin
         alt[i]  = (i % 2 == 0);
         alt2[i] = ((i / 2) % 2 == 0);
      end
      sel    = 1'b0;
      rst_n  = 1'b0;
      start0 = 1'b0;
      start1 = 1'b0;
      x      = 1'b0;
      y      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy0, 0);
      check("rst_done", done0, 0);
      check("rst_valid", valid0, 0);
      check("rst_cnt_x", cx0, 0);
      check("rst_cnt_y", cy0, 0);
      check("rst_cnt_xy", cxy0, 0);
      check("rst_pos", pos0, 0);
      check("rst_neg", neg0, 0);
      check("rst_busy_l2", busy1, 0);
      check("rst_valid_l2", valid1, 0);
      @(negedge clk);
      rst_n = 1'b1;

      run_window(1'b0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_window(1'b0, 0, alt, alt, 1'b0);
      run_window(1'b0, 0, alt, ~alt, 1'b0);
      run_window(1'b0, 0, alt2, alt, 1'b1);
      run_window(1'b1, 2, 32'h0000_0003, 32'h0000_0003, 1'b0);

      // Reset at sample 9 of a window: everything clears and no done follows.
      sel = 1'b0;
      @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      x = 1'b1;
      y = 1'b1;
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy0, 0);
      check("mid_rst_valid", valid0, 0);
      check("mid_rst_done", done0, 0);
      check("mid_rst_cnt_x", cx0, 0);
      check("mid_rst_cnt_xy", cxy0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      dn = 0;
      for (int k = 0; k < 24; k++) begin
         @(posedge clk);
         #1;
         if (done0) dn++;
      end
      check("no_done_after_rst", dn, 0);
      check("idle_after_rst", busy0, 0);

      for (int r = 0; r < 3; r++) begin
         rx = $urandom();
         ry = $urandom();
         run_window(1'b0, 0, rx, ry, 1'b0);
         run_window(1'b1, 2, ry, rx, 1'b0);
      end

      check("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
